// File: rtl/gate_truth_table_checker.sv
// ============================================================================
// Module      : gate_truth_table_checker
// Description : Walks a two-input gate unit (AND, OR, NOT-of-A) through all
//               four input vectors and reports per-vector and per-gate faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_truth_table_checker #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iStart,
    output logic       oA,
    output logic       oB,
    input  logic       iAnd,
    input  logic       iOr,
    input  logic       iNot,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [2:0] oErrCnt,
    output logic [3:0] oErrMask,
    output logic [2:0] oFailBits
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [3:0] c_SETTLE_LAST = 4'(HOLD_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_vec;
    logic [3:0] r_settle;

    logic       w_expAnd;
    logic       w_expOr;
    logic       w_expNot;
    logic [2:0] w_gateFail;
    logic       w_vecFail;
    logic [2:0] w_errCntNext;
    logic [1:0] w_vecNext;

    // Expected values follow directly from the vector index: A = v[1], B = v[0].
    assign w_expAnd     = r_vec[1] & r_vec[0];
    assign w_expOr      = r_vec[1] | r_vec[0];
    assign w_expNot     = ~r_vec[1];
    assign w_gateFail   = {iNot != w_expNot, iOr != w_expOr, iAnd != w_expAnd};
    assign w_vecFail    = |w_gateFail;
    assign w_errCntNext = oErrCnt + {2'b00, w_vecFail};
    assign w_vecNext    = r_vec + 2'd1;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state   <= c_IDLE;
            r_vec     <= 2'd0;
            r_settle  <= 4'd0;
            oA        <= 1'b0;
            oB        <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oPass     <= 1'b0;
            oErrCnt   <= 3'd0;
            oErrMask  <= 4'd0;
            oFailBits <= 3'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    oA <= 1'b0;
                    oB <= 1'b0;
                    if (iStart) begin
                        oPass     <= 1'b0;
                        oErrCnt   <= 3'd0;
                        oErrMask  <= 4'd0;
                        oFailBits <= 3'd0;
                        r_vec     <= 2'd0;
                        r_settle  <= 4'd0;
                        oBusy     <= 1'b1;
                        r_state   <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_state <= c_CHECK;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                c_CHECK: begin
                    // A vector counts once no matter how many gates disagree.
                    if (w_vecFail) begin
                        oErrMask  <= oErrMask | (4'b0001 << r_vec);
                        oErrCnt   <= w_errCntNext;
                        oFailBits <= oFailBits | w_gateFail;
                    end
                    if (r_vec == 2'd3) begin
                        oA      <= 1'b0;
                        oB      <= 1'b0;
                        oBusy   <= 1'b0;
                        oDone   <= 1'b1;
                        oPass   <= (w_errCntNext == 3'd0);
                        r_state <= c_DONE;
                    end else begin
                        r_vec    <= w_vecNext;
                        oA       <= w_vecNext[1];
                        oB       <= w_vecNext[0];
                        r_settle <= 4'd0;
                        r_state  <= c_WAIT;
                    end
                end
                c_DONE: begin
                    oDone   <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_table_checker.sv
// ============================================================================
// Module      : tb_gate_truth_table_checker
// Description : Directed scoreboard bench with a fault-injectable gate model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_truth_table_checker;

    typedef struct packed {
        logic       pass;
        logic [2:0] cnt;
        logic [3:0] mask;
        logic [2:0] fb;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start1, start3;
    logic fAnd0, fAnd1, fOr1, fNot0;
    int   sel;

    logic a1, b1, busy1, done1, pass1, gAnd1, gOr1, gNot1;
    logic [2:0] cnt1, fb1;
    logic [3:0] mask1;
    logic a3, b3, busy3, done3, pass3, gAnd3, gOr3, gNot3;
    logic [2:0] cnt3, fb3;
    logic [3:0] mask3;

    assign gAnd1 = fAnd0 ? 1'b0 : (fAnd1 ? 1'b1 : (a1 & b1));
    assign gOr1  = fOr1  ? 1'b1 : (a1 | b1);
    assign gNot1 = fNot0 ? 1'b0 : ~a1;
    assign gAnd3 = fAnd0 ? 1'b0 : (fAnd1 ? 1'b1 : (a3 & b3));
    assign gOr3  = fOr1  ? 1'b1 : (a3 | b3);
    assign gNot3 = fNot0 ? 1'b0 : ~a3;

    gate_truth_table_checker #(.HOLD_CYCLES(1)) dut1 (
        .iClk(clk), .iRst_n(rstn), .iStart(start1), .oA(a1), .oB(b1),
        .iAnd(gAnd1), .iOr(gOr1), .iNot(gNot1), .oBusy(busy1), .oDone(done1),
        .oPass(pass1), .oErrCnt(cnt1), .oErrMask(mask1), .oFailBits(fb1)
    );

    gate_truth_table_checker #(.HOLD_CYCLES(3)) dut3 (
        .iClk(clk), .iRst_n(rstn), .iStart(start3), .oA(a3), .oB(b3),
        .iAnd(gAnd3), .iOr(gOr3), .iNot(gNot3), .oBusy(busy3), .oDone(done3),
        .oPass(pass3), .oErrCnt(cnt3), .oErrMask(mask3), .oFailBits(fb3)
    );

    logic       oa, ob, obusy, odone, opass;
    logic [2:0] ocnt, ofb;
    logic [3:0] omask;
    assign oa    = (sel == 3) ? a3    : a1;
    assign ob    = (sel == 3) ? b3    : b1;
    assign obusy = (sel == 3) ? busy3 : busy1;
    assign odone = (sel == 3) ? done3 : done1;
    assign opass = (sel == 3) ? pass3 : pass1;
    assign ocnt  = (sel == 3) ? cnt3  : cnt1;
    assign omask = (sel == 3) ? mask3 : mask1;
    assign ofb   = (sel == 3) ? fb3   : fb1;

    res_t       resQ[$];
    logic [2:0] abQ[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setStart(input int s, input logic val);
        if (s == 3) start3 = val;
        else        start1 = val;
    endtask

    // Returns one sample point after the accept edge.
    task automatic pulseStart(input int s);
        @(negedge clk);
        setStart(s, 1'b1);
        @(posedge clk);
        #1;
        setStart(s, 1'b0);
    endtask

    task automatic doRun(input int s, input int hold, input res_t e, input int rePulseAt);
        int   doneAt;
        res_t r;
        sel = s;
        for (int v = 0; v < 4; v++)
            for (int h = 0; h <= hold; h++)
                abQ.push_back({1'b1, 2'(v)});
        resQ.push_back(e);
        pulseStart(s);
        check("accept_clear", {12'd0, opass, ocnt}, 16'd0);
        check("accept_mask", {8'd0, omask, 1'b0, ofb}, 16'd0);
        doneAt = -1;
        for (int k = 0; k <= 4 * (hold + 1) + 4 && doneAt < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            setStart(s, k == rePulseAt);
            if (odone) doneAt = k;
            else if (abQ.size() > 0) check("busy_ab", {13'd0, obusy, oa, ob}, {13'd0, abQ.pop_front()});
        end
        setStart(s, 1'b0);
        check("done_latency", 16'(doneAt), 16'(4 * (hold + 1)));
        r = resQ.pop_front();
        if (doneAt >= 0) begin
            check("result", {5'd0, opass, ocnt, omask, ofb}, {5'd0, r});
            check("done_ab_busy", {13'd0, obusy, oa, ob}, 16'd0);
            @(posedge clk);
            #1;
            check("done_pulse", {15'd0, odone}, 16'd0);
            check("result_held", {5'd0, opass, ocnt, omask, ofb}, {5'd0, r});
        end
        abQ.delete();
    endtask

    initial begin
        rstn = 1'b0; start1 = 1'b0; start3 = 1'b0; sel = 1;
        fAnd0 = 1'b0; fAnd1 = 1'b0; fOr1 = 1'b0; fNot0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset1", {1'b0, a1, b1, busy1, done1, pass1, cnt1, mask1, fb1}, 16'd0);
        check("reset3", {1'b0, a3, b3, busy3, done3, pass3, cnt3, mask3, fb3}, 16'd0);
        rstn = 1'b1;

        doRun(1, 1, '{pass: 1'b1, cnt: 3'd0, mask: 4'b0000, fb: 3'b000}, -1);
        fAnd0 = 1'b1;
        doRun(1, 1, '{pass: 1'b0, cnt: 3'd1, mask: 4'b1000, fb: 3'b001}, -1);
        fAnd0 = 1'b0; fNot0 = 1'b1;
        doRun(1, 1, '{pass: 1'b0, cnt: 3'd2, mask: 4'b0011, fb: 3'b100}, -1);
        fNot0 = 1'b0; fOr1 = 1'b1; fAnd1 = 1'b1;
        doRun(1, 1, '{pass: 1'b0, cnt: 3'd3, mask: 4'b0111, fb: 3'b011}, -1);
        fOr1 = 1'b0; fAnd1 = 1'b0;
        doRun(1, 1, '{pass: 1'b1, cnt: 3'd0, mask: 4'b0000, fb: 3'b000}, 2);

        // Mid-run reset with partial failures already recorded.
        fNot0 = 1'b1;
        sel = 1;
        pulseStart(1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset", {1'b0, a1, b1, busy1, done1, pass1, cnt1, mask1, fb1},
              {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'b0011, 3'b100});
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("reset_mid", {1'b0, a1, b1, busy1, done1, pass1, cnt1, mask1, fb1}, 16'd0);
        @(posedge clk);
        #1;
        check("reset_idle", {1'b0, a1, b1, busy1, done1, pass1, cnt1, mask1, fb1}, 16'd0);
        fNot0 = 1'b0;
        doRun(1, 1, '{pass: 1'b1, cnt: 3'd0, mask: 4'b0000, fb: 3'b000}, -1);

        fAnd0 = 1'b1;
        doRun(3, 3, '{pass: 1'b0, cnt: 3'd1, mask: 4'b1000, fb: 3'b001}, -1);
        fAnd0 = 1'b0;
        doRun(3, 3, '{pass: 1'b1, cnt: 3'd0, mask: 4'b0000, fb: 3'b000}, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
Self-checking stimulus and capture stage wrapped around a two-input basic gate unit (AND, OR, NOT-of-A).
- Drives the unit's A/B inputs through all four input combinations.
- Samples its three outputs after a programmable settle time and compares them with expected truth-table values.
- Reports pass/fail, a per-vector error mask and a per-gate fail summary.
- Used on the board between the switch/button front end and the LED display.

Parameters:
HOLD_CYCLES, 1, settle cycles between applying a vector and sampling the gate outputs; legal range 1..15.

Ports:
iClk  input  1  system clock, rising edge
iRst_n  input  1  synchronous reset, active-low
iStart  input  1  start request; accepted only in IDLE
oA  output  1  stimulus to gate unit input A
oB  output  1  stimulus to gate unit input B
iAnd  input  1  AND result returned from gate unit
iOr  input  1  OR result returned from gate unit
iNot  input  1  NOT-of-A result returned from gate unit
oBusy  output  1  high while a run is in progress
oDone  output  1  one-cycle pulse at end of run
oPass  output  1  1 = last run had zero mismatches; valid from oDone, held until next accepted start
oErrCnt  output  3  number of failing vectors in last run, 0..4
oErrMask  output  4  bit v set = vector v failed
oFailBits  output  3  sticky per-gate failure: [0] AND, [1] OR, [2] NOT

Behaviour:
- Reset is synchronous: iRst_n=0 at a rising edge forces state IDLE, vector index v=0, settle counter=0, and all outputs (oA, oB, oBusy, oDone, oPass, oErrCnt, oErrMask, oFailBits) to 0. This applies in every state, including mid-run; no partial results are retained.
- Vector encoding: oA=v[1], oB=v[0]; v runs 0,1,2,3 (AB=00,01,10,11).
- Expected values: AND=A&B, OR=A|B, NOT=~A.
- States:
  - IDLE: oA=oB=0, oBusy=0. When iStart=1 at an edge: clear oPass, oErrCnt, oErrMask, oFailBits; set v=0, oA/oB=00, oBusy=1, settle counter=0; go to WAIT.
  - WAIT: hold oA/oB. Increment the settle counter each cycle. After HOLD_CYCLES cycles in WAIT, go to CHECK.
  - CHECK (exactly 1 cycle): at the edge, compare iAnd/iOr/iNot against expected for v.
    - On any mismatch: set oErrMask[v], increment oErrCnt by 1 (per vector, not per gate), and OR the failing gate bits into oFailBits.
    - If v<3: v=v+1, drive the new vector, clear the counter, go to WAIT.
    - If v=3: oA/oB=00, oBusy=0, oDone=1, oPass=(final error count==0, including this vector's result); go to DONE.
  - DONE (1 cycle): oDone returns to 0 at the next edge; go to IDLE.
- Latency:
  - Each vector occupies HOLD_CYCLES+1 cycles.
  - oDone is high in the cycle starting 4*(HOLD_CYCLES+1) edges after the start-accept edge; this is 8 for the default.
  - The gate unit is combinational, so its outputs are sampled at least one full cycle after the vector changes.
- iStart is ignored in WAIT, CHECK and DONE; no queuing. A start held high continuously restarts at the first IDLE edge after DONE.
- Result outputs are stable from DONE until the next accepted start or reset.
- oErrCnt cannot wrap: the maximum is 4 and it fits in 3 bits.
- iAnd/iOr/iNot are don't-care outside CHECK.

Test Plan:
- Correct gate unit connected, HOLD_CYCLES=1, pulse iStart -> oA/oB sequence 00,01,10,11 with 2 cycles each; oDone pulses exactly 8 cycles after the accept edge; oPass=1, oErrCnt=0, oErrMask=0000, oFailBits=000.
- iAnd forced 0 -> only v=3 fails: oPass=0, oErrCnt=1, oErrMask=1000, oFailBits=001.
- iNot forced 0 -> v=0 and v=1 fail: oErrCnt=2, oErrMask=0011, oFailBits=100.
- iOr forced 1 and iAnd forced 1 -> v=0 fails both gates, v=1 and v=2 fail AND: oErrCnt=3, oErrMask=0111, oFailBits=011.
- iStart re-pulsed at cycle 3 of a run -> ignored, oDone still at cycle 8. iRst_n=0 at cycle 5 -> next edge: all outputs 0, IDLE. A fresh start then runs normally.
- HOLD_CYCLES=3: oDone at cycle 16. A second run after a failing run clears the prior oErrMask/oErrCnt on the accept edge and reports oPass=1.
